// File: rtl/sa48_ctrl.sv
// Sequencer for the 48-bit serial adder: accepts an operand pair, clears the datapath,
// streams four 12-bit chunks LSB-first with shift strobes, then holds the sum for the consumer.
module sa48_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] opA,
  input  logic [47:0] opB,
  output logic [11:0] busA,
  output logic [11:0] busB,
  output logic        init0,
  output logic        shift_12bR,
  input  logic [47:0] sum_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, INIT, ADD, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  k_reg, k_next;
  logic [47:0] op_a_reg, op_b_reg;
  logic        accept;

  logic [11:0] chunk_a [4];
  logic [11:0] chunk_b [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chunk
      assign chunk_a[gi] = op_a_reg[gi*12 +: 12];
      assign chunk_b[gi] = op_b_reg[gi*12 +: 12];
    end
  endgenerate

  // A result consumed in DONE frees the slot in the same cycle, allowing back-to-back operations.
  assign in_ready = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= 2'd0;
      op_a_reg  <= 48'd0;
      op_b_reg  <= 48'd0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      if (accept) begin
        op_a_reg <= opA;
        op_b_reg <= opB;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    init0      = 1'b0;
    shift_12bR = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    busA       = 12'd0;
    busB       = 12'd0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = INIT;
      end
      INIT: begin
        init0      = 1'b1;
        busy       = 1'b1;
        k_next     = 2'd0;
        state_next = ADD;
      end
      ADD: begin
        shift_12bR = 1'b1;
        busy       = 1'b1;
        busA       = chunk_a[k_reg];
        busB       = chunk_b[k_reg];
        k_next     = k_reg + 2'd1;
        if (k_reg == 2'd3) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = accept ? INIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The datapath holds its register while shift_12bR is low, so the sum is passed straight through.
  assign result = sum_in;

endmodule

// File: tb/tb_sa48_ctrl.sv
// Self-checking bench for sa48_ctrl with a behavioural 12-bit-slice serial adder datapath;
// expected sums come from plain 48-bit modular addition.
module tb_sa48_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] opA;
  logic [47:0] opB;
  logic [11:0] busA;
  logic [11:0] busB;
  logic        init0;
  logic        shift_12bR;
  logic [47:0] sum_in;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  sa48_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opA        (opA),
    .opB        (opB),
    .busA       (busA),
    .busB       (busB),
    .init0      (init0),
    .shift_12bR (shift_12bR),
    .sum_in     (sum_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: carry flop plus 48-bit register shifting right by one chunk per strobe.
  logic [47:0] dp_reg;
  logic        dp_carry;
  logic [12:0] dp_sum;
  assign dp_sum = {1'b0, busA} + {1'b0, busB} + {12'd0, dp_carry};
  assign sum_in = dp_reg;

  always @(posedge clk) begin
    if (rst || init0) begin
      dp_reg   <= 48'd0;
      dp_carry <= 1'b0;
    end else if (shift_12bR) begin
      dp_reg   <= {dp_sum[11:0], dp_reg[47:12]};
      dp_carry <= dp_sum[12];
    end
  end

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opA = 48'd0; opB = 48'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready_during_rst: got %b want 0", in_ready);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, init0, shift_12bR, busy} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctl: got %b want 10000", {in_ready, out_valid, init0, shift_12bR, busy});
    end
    total++;
    if ({busA, busB} !== 24'd0 || result !== 48'd0) begin
      bad++; $display("FAIL reset_bus: got busA=%h busB=%h result=%h want 0", busA, busB, result);
    end
    $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
  endtask

  // One complete operation from IDLE with out_ready high, checking every cycle of the sequence.
  task automatic run_op(input logic [47:0] a, input logic [47:0] b, input string name);
    logic [47:0] exp_sum;
    logic [3:0]  exp_ctl;
    logic [11:0] exp_a, exp_b;
    exp_sum = a + b;
    @(posedge clk); #1;
    in_valid = 1'b1; opA = a; opB = b; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; opA = rnd48(); opB = rnd48();
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      exp_ctl = (n == 1) ? 4'b1010 : (n <= 5) ? 4'b0110 : 4'b0001;
      exp_a = (n >= 2 && n <= 5) ? a[12*(n-2) +: 12] : 12'd0;
      exp_b = (n >= 2 && n <= 5) ? b[12*(n-2) +: 12] : 12'd0;
      total++;
      if ({init0, shift_12bR, busy, out_valid} !== exp_ctl) begin
        bad++; $display("FAIL %s_ctl_T+%0d: got %b want %b", name, n,
                        {init0, shift_12bR, busy, out_valid}, exp_ctl);
      end
      total++;
      if ({busA, busB} !== {exp_a, exp_b}) begin
        bad++; $display("FAIL %s_bus_T+%0d: got %h/%h want %h/%h", name, n, busA, busB, exp_a, exp_b);
      end
    end
    total++;
    if (result !== exp_sum) begin
      bad++; $display("FAIL %s_result: got %h want %h", name, result, exp_sum);
    end
    $display("op %s: %h + %h -> %h (expect %h)", name, a, b, result, exp_sum);
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++; $display("FAIL %s_idle_after: got %b want 001", name, {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_basic();
    run_op(48'h0123456789AB, 48'h111111111111, "basic");
  endtask

  task automatic test_carry();
    run_op(48'h000000000FFF, 48'h000000000001, "chunk_carry");
    run_op(48'hFFFFFFFFFFFF, 48'h000000000001, "wrap");
  endtask

  task automatic test_stale_carry();
    run_op(48'hFFFFFFFFFFFF, 48'h000000000001, "stale_first");
    run_op(48'h000000000000, 48'h000000000000, "stale_second");
  endtask

  task automatic test_backpressure();
    logic [47:0] a, b, exp_sum;
    int lat;
    a = rnd48(); b = rnd48(); exp_sum = a + b; lat = -1;
    @(posedge clk); #1;
    in_valid = 1'b1; opA = a; opB = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) lat = i;
    end
    total++;
    if (lat != 6) begin
      bad++; $display("FAIL bp_latency: got %0d want 6", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; opA = rnd48(); opB = rnd48();
      @(negedge clk);
      total++;
      if (result !== exp_sum || {out_valid, in_ready, shift_12bR} !== 3'b100) begin
        bad++; $display("FAIL bp_hold_%0d: got result=%h ctl=%b want %h 100", i, result,
                        {out_valid, in_ready, shift_12bR}, exp_sum);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b11) begin
      bad++; $display("FAIL bp_release: got %b want 11", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({out_valid, busy, in_ready, init0} !== 4'b0010) begin
      bad++; $display("FAIL bp_idle: got %b want 0010", {out_valid, busy, in_ready, init0});
    end
    $display("backpressure: %h + %h held -> %h", a, b, exp_sum);
  endtask

  task automatic test_back_to_back();
    logic [47:0] qa [3];
    logic [47:0] qb [3];
    int idx_in, idx_out, last, fire;
    for (int i = 0; i < 3; i++) begin
      qa[i] = rnd48(); qb[i] = rnd48();
    end
    idx_in = 0; idx_out = 0; last = -1;
    @(posedge clk); #1;
    in_valid = 1'b1; opA = qa[0]; opB = qb[0]; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && idx_out < 3; cyc++) begin
      @(negedge clk);
      fire = (in_valid && in_ready) ? 1 : 0;
      if (out_valid === 1'b1) begin
        total++;
        if (result !== qa[idx_out] + qb[idx_out]) begin
          bad++; $display("FAIL b2b_result_%0d: got %h want %h", idx_out, result, qa[idx_out] + qb[idx_out]);
        end
        total++;
        if (in_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_in_ready_%0d: got %b want 1", idx_out, in_ready);
        end
        if (idx_out > 0) begin
          total++;
          if (cyc - last != 6) begin
            bad++; $display("FAIL b2b_spacing_%0d: got %0d want 6", idx_out, cyc - last);
          end
        end
        $display("b2b op %0d: %h + %h -> %h", idx_out, qa[idx_out], qb[idx_out], result);
        last = cyc;
        idx_out++;
      end
      @(posedge clk); #1;
      if (fire != 0) begin
        idx_in++;
        if (idx_in < 3) begin
          opA = qa[idx_in]; opB = qb[idx_in];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    total++;
    if (idx_out != 3) begin
      bad++; $display("FAIL b2b_timeout: got %0d results want 3", idx_out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [47:0] a, b;
    a = 48'hABCDEF012345; b = 48'h13579BDF0246;
    @(posedge clk); #1;
    in_valid = 1'b1; opA = a; opB = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    total++;
    if (busA !== a[35:24] || in_ready !== 1'b0 || shift_12bR !== 1'b1) begin
      bad++; $display("FAIL rstmid_k2: got busA=%h in_ready=%b shift=%b want %h 0 1",
                      busA, in_ready, shift_12bR, a[35:24]);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, out_valid, shift_12bR, init0, in_ready} !== 5'b00001 || {busA, busB} !== 24'd0) begin
      bad++; $display("FAIL rstmid_idle: got ctl=%b busA=%h busB=%h want 00001 0 0",
                      {busy, out_valid, shift_12bR, init0, in_ready}, busA, busB);
    end
    $display("reset mid-operation: busy=%b out_valid=%b", busy, out_valid);
    run_op(48'h5, 48'h7, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(rnd48(), rnd48(), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_stale_carry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
